// File: rtl/controle_execucao.sv
// rtl/controle_execucao.sv - execution controller driving the clock divider halt/congela inputs
module controle_execucao #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clock_fpga,
  input  logic       reset_n,
  input  logic       btn_continua,
  input  logic       sw_passo,
  input  logic       instr_halt,
  input  logic       instr_in,
  input  logic       tick,
  output logic       halt,
  output logic       congela,
  output logic       entrada_ok,
  output logic [2:0] estado
);

  localparam logic [2:0] ST_RUN       = 3'b000;
  localparam logic [2:0] ST_PAUSE_IN  = 3'b001;
  localparam logic [2:0] ST_HALTED    = 3'b010;
  localparam logic [2:0] ST_STEP_WAIT = 3'b011;
  localparam logic [2:0] ST_STEP_RUN  = 3'b100;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_press;

  logic [2:0]       state_q, state_d;
  logic             halt_q, halt_d;
  logic             congela_q, congela_d;
  logic             entrada_ok_q, entrada_ok_d;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clock_fpga) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_continua;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive cycles the synchronized input disagrees with the stable level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // The press is consumed on the same edge that the stable level rises.
  assign btn_press = stable_d & ~stable_q;

  // Debounce state registers.
  always_ff @(posedge clock_fpga) begin
    if (!reset_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and pulse decode; presses in RUN/STEP_RUN/HALTED are simply dropped.
  always_comb begin
    state_d      = state_q;
    congela_d    = 1'b0;
    entrada_ok_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (instr_halt)    state_d = ST_HALTED;
        else if (instr_in) state_d = ST_PAUSE_IN;
        else if (sw_passo) state_d = ST_STEP_WAIT;
      end
      ST_PAUSE_IN: begin
        if (btn_press) begin
          state_d      = ST_RUN;
          congela_d    = 1'b1;
          entrada_ok_d = 1'b1;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      ST_STEP_WAIT: begin
        if (instr_halt)     state_d = ST_HALTED;
        else if (instr_in)  state_d = ST_PAUSE_IN;
        else if (!sw_passo) state_d = ST_RUN;
        else if (btn_press) begin
          state_d   = ST_STEP_RUN;
          congela_d = 1'b1;
        end
      end
      ST_STEP_RUN: begin
        if (tick) state_d = sw_passo ? ST_STEP_WAIT : ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    halt_d = (state_d == ST_PAUSE_IN) || (state_d == ST_HALTED) ||
             (state_d == ST_STEP_WAIT);
  end

  // State and registered outputs update together so halt tracks estado exactly.
  always_ff @(posedge clock_fpga) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      halt_q       <= 1'b0;
      congela_q    <= 1'b0;
      entrada_ok_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      halt_q       <= halt_d;
      congela_q    <= congela_d;
      entrada_ok_q <= entrada_ok_d;
    end
  end

  assign estado     = state_q;
  assign halt       = halt_q;
  assign congela    = congela_q;
  assign entrada_ok = entrada_ok_q;

endmodule
